branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the ceRV32 execute stage. It accepts one branch or jump from decode over a valid/ready handshake and registers the operands. It evaluates the RV32I branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU) and computes the target and link value. On a misprediction it issues a held redirect to fetch, and it aborts cleanly when a pipeline flush arrives.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; **asynchronous, active-low**.
- br_valid  in  1  decode presents a branch or jump.
- br_ready  out  1  controller can accept; 1 only in IDLE.
- br_op  in  2  00 = conditional branch, 01 = JAL, 10 = JALR, 11 = reserved (treated as illegal).
- br_func3  in  3  branch condition code.
- br_pc  in  32  PC of the instruction.
- br_imm  in  32  sign-extended immediate.
- br_rs1, br_rs2  in  32  operands.
- br_pred_taken  in  1  fetch predicted taken.
- flush_in  in  1  kill from an older instruction.
- res_valid  out  1  one-cycle resolve pulse.
- res_taken  out  1  actual direction.
- res_mispredict  out  1  direction differed from prediction.
- res_link  out  32  br_pc+4, for the JAL/JALR rd write.
- res_illegal  out  1  reserved br_op or func3 010/011.
- res_misalign  out  1  taken target with bit1 set.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  32  redirect address.
- redirect_ready  in  1  fetch accepts the redirect.

## Operation
- FSM states: IDLE, EVAL, REDIRECT. Reset state is IDLE.
- IDLE: br_ready=1. When br_valid & !flush_in, latch all br_* fields and go to EVAL.
- EVAL: compute the result from the latched fields.
  - Conditional branch, by func3:
    - 000: eq.
    - 001: ne.
    - 100: signed lt.
    - 101: signed ge.
    - 110: unsigned lt.
    - 111: unsigned ge.
    - 010/011: res_illegal=1, taken=0.
  - JAL and JALR: taken=1.
  - Target:
    - Branch and JAL: pc+imm, mod 2^32.
    - JALR: (rs1+imm) & ~1, mod 2^32.
  - Link: pc+4, which wraps 0xFFFFFFFC→0.
  - Misalign: taken & target[1] → res_misalign=1. No redirect is issued on misalign.
  - Mispredict: taken != pred_taken, not illegal, not misalign.
  - redirect_pc = taken ? target : pc+4.
  - Next state is REDIRECT on mispredict, otherwise IDLE.
- REDIRECT: hold redirect_valid=1 with a stable redirect_pc until redirect_ready, then go to IDLE.
- flush_in has highest priority in every state:
  - Next state is IDLE.
  - A flush in EVAL suppresses res_valid and the redirect.
  - A flush in REDIRECT drops redirect_valid on the next cycle.
  - A flush in IDLE blocks acceptance that cycle.
- Registered outputs hold their last value between pulses. res_valid and redirect_valid return to 0.

## Timing
- Reset: all outputs are 0, except br_ready=1. State is IDLE. Latched fields are 0.
- The handshake accepts on the edge where br_valid & br_ready are both high (edge E0).
- Edge E1 (end of EVAL):
  - res_* registers load and res_valid=1 for exactly one cycle.
  - On mispredict, redirect_valid rises in the same cycle as res_valid.
- Throughput: one instruction per 2 cycles with no mispredict. br_ready is low in EVAL and REDIRECT.
- Redirect: completes on the first edge where redirect_valid & redirect_ready. br_ready returns to 1 in the following cycle.
- redirect_ready high on the same cycle redirect_valid first rises: the redirect completes in one cycle.
- rst_n deasserted mid-operation: all state clears immediately, without waiting for a clock edge.
- Simultaneous br_valid and flush_in in IDLE: no accept, br_ready remains 1.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=0 → res_valid 2 cycles after accept, taken=1, mispredict=1, redirect_pc=0x120.
- BLT with rs1=0xFFFFFFFF, rs2=1 → taken=1. BLTU with the same operands → taken=0. With pred matching in both cases, no redirect.
- JALR, rs1=0x1003, imm=0x0, pc=0x200, pred_taken=0 → target=0x1002, misalign=1, link=0x204, no redirect. Repeat with rs1=0x1001 → redirect_pc=0x1000.
- Mispredict with redirect_ready held low 3 cycles → redirect_valid and redirect_pc stable for 4 cycles, br_ready=0 throughout, then IDLE.
- flush_in asserted in EVAL → no res_valid, no redirect. Asserted in REDIRECT → redirect_valid=0 on the next cycle, br_ready=1.
- br_op=00, func3=010 → res_illegal=1, taken=0, no redirect. Async reset pulsed mid-REDIRECT → all outputs at reset values immediately.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the execute stage:
// evaluates branch/jump, produces link/target and fetch redirects.
module branch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_op,
  input  logic [2:0]      br_func3,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic            br_pred_taken,
  input  logic            flush_in,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [XLEN-1:0] res_link,
  output logic            res_illegal,
  output logic            res_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]      op_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic            pred_q;

  logic            accept, resolve;
  logic            is_br, is_jal, is_jalr;
  logic            eq, lt, ltu, cond, cond_ok;
  logic            illegal, taken, misalign, mispred;
  logic [XLEN-1:0] base, target, link, rpc;

  assign accept  = br_ready & br_valid & ~flush_in;
  assign resolve = (state_q == EVAL) & ~flush_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      f3_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pred_q <= 1'b0;
    end else if (accept) begin
      op_q   <= br_op;
      f3_q   <= br_func3;
      pc_q   <= br_pc;
      imm_q  <= br_imm;
      rs1_q  <= br_rs1;
      rs2_q  <= br_rs2;
      pred_q <= br_pred_taken;
    end
  end

  always_comb begin
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    unique case (1'b1)
      (op_q == 2'b00): is_br   = 1'b1;
      (op_q == 2'b01): is_jal  = 1'b1;
      (op_q == 2'b10): is_jalr = 1'b1;
      default: ;
    endcase
  end

  assign eq  = rs1_q == rs2_q;
  assign lt  = $signed(rs1_q) < $signed(rs2_q);
  assign ltu = rs1_q < rs2_q;

  always_comb begin
    cond    = 1'b0;
    cond_ok = 1'b1;
    case (f3_q)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond_ok = 1'b0;
    endcase
  end

  // JALR clears bit 0 of its sum; branches and JAL are pc-relative
  assign base     = is_jalr ? rs1_q : pc_q;
  assign target   = (base + imm_q)
                  & ~{{(XLEN-1){1'b0}}, is_jalr};
  assign link     = pc_q + XLEN'(4);
  assign illegal  = ~(is_br | is_jal | is_jalr)
                  | (is_br & ~cond_ok);
  assign taken    = (is_br & cond) | is_jal | is_jalr;
  assign misalign = taken & target[1];
  assign mispred  = (taken ^ pred_q) & ~illegal & ~misalign;
  assign rpc      = taken ? target : link;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    br_ready       = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid && !flush_in) state_d = EVAL;
      end
      EVAL: begin
        if (mispred && !flush_in) state_d = REDIRECT;
        else                      state_d = IDLE;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (flush_in || redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_link       <= '0;
      res_illegal    <= 1'b0;
      res_misalign   <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      res_valid <= resolve;
      if (resolve) begin
        res_taken      <= taken;
        res_mispredict <= mispred;
        res_link       <= link;
        res_illegal    <= illegal;
        res_misalign   <= misalign;
        redirect_pc    <= rpc;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: random branches/jumps
// checked against an arithmetic reference model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [1:0]  br_op = '0;
  logic [2:0]  br_func3 = '0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_imm = '0;
  logic [31:0] br_rs1 = '0;
  logic [31:0] br_rs2 = '0;
  logic        br_pred_taken = 1'b0;
  logic        flush_in = 1'b0;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] res_link;
  logic        res_illegal;
  logic        res_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        taken;
    logic        mispred;
    logic        illegal;
    logic        misalign;
    logic        redir;
    logic [31:0] link;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];

  branch_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_op          (br_op),
    .br_func3       (br_func3),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .br_rs1         (br_rs1),
    .br_rs2         (br_rs2),
    .br_pred_taken  (br_pred_taken),
    .flush_in       (flush_in),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .res_link       (res_link),
    .res_illegal    (res_illegal),
    .res_misalign   (res_misalign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: RV32I branch semantics in plain arithmetic
  function automatic exp_t model(input logic [1:0] op,
                                 input logic [2:0] f3,
                                 input logic [31:0] pc,
                                 input logic [31:0] imm,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic pred);
    exp_t e;
    int sa, sb;
    logic [31:0] tgt;
    sa = int'(a);
    sb = int'(b);
    e.illegal = (op == 2'd3) ||
                (op == 2'd0 && (f3 == 3'd2 || f3 == 3'd3));
    e.taken = 1'b0;
    if (op == 2'd1 || op == 2'd2) e.taken = 1'b1;
    if (op == 2'd0) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = (sa >= sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.taken = 1'b0;
      endcase
    end
    if (op == 2'd2) tgt = (a + imm) & 32'hFFFF_FFFE;
    else            tgt = pc + imm;
    e.link     = pc + 32'd4;
    e.misalign = e.taken && tgt[1];
    e.mispred  = (e.taken != pred) && !e.illegal
                 && !e.misalign;
    e.redir    = e.mispred;
    e.rpc      = e.taken ? tgt : e.link;
    return e;
  endfunction

  // Monitor: pops on every resolve pulse, tracks held redirects
  logic [31:0] hold_pc = '0;
  bit          active = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("res_taken", 32'(res_taken), 32'(e.taken));
          chk("res_mispredict", 32'(res_mispredict),
              32'(e.mispred));
          chk("res_illegal", 32'(res_illegal), 32'(e.illegal));
          chk("res_misalign", 32'(res_misalign),
              32'(e.misalign));
          chk("res_link", res_link, e.link);
          chk("redirect_valid_rise", 32'(redirect_valid),
              32'(e.redir));
          if (e.redir) begin
            chk("redirect_pc", redirect_pc, e.rpc);
            hold_pc = e.rpc;
            active  = 1'b1;
          end
        end
      end else if (redirect_valid) begin
        if (!active) begin
          checks++;
          errors++;
          $display("FAIL spurious_redirect at %0t", $time);
        end else begin
          chk("redirect_pc_hold", redirect_pc, hold_pc);
          chk("br_ready_in_redirect", 32'(br_ready), 32'd0);
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // mode: 0 normal, 1 flush in EVAL, 2 flush in REDIRECT,
  // 3 async reset in REDIRECT
  task automatic send(input logic [1:0] op,
                      input logic [2:0] f3,
                      input logic [31:0] pc,
                      input logic [31:0] imm,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic pred,
                      input int mode_in,
                      input int dly);
    exp_t e;
    int n;
    int mode;
    mode = mode_in;
    e = model(op, f3, pc, imm, a, b, pred);
    if (!e.redir && mode > 1) mode = 0;
    if (mode != 1) exp_q.push_back(e);
    n = 0;
    while (!br_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("br_ready_wait", 32'(br_ready), 32'd1);
    br_op = op;
    br_func3 = f3;
    br_pc = pc;
    br_imm = imm;
    br_rs1 = a;
    br_rs2 = b;
    br_pred_taken = pred;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    br_op = 2'($urandom_range(0, 3));
    br_rs1 = $urandom;
    br_pc = $urandom;
    chk("br_ready_eval", 32'(br_ready), 32'd0);
    if (mode == 1) begin
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      chk("flush_eval_res", 32'(res_valid), 32'd0);
      chk("flush_eval_redir", 32'(redirect_valid), 32'd0);
      chk("flush_eval_ready", 32'(br_ready), 32'd1);
      return;
    end
    redirect_ready = (dly == 0) && (mode == 0);
    @(negedge clk);
    chk("res_latency", 32'(res_valid), 32'd1);
    if (!e.redir) begin
      chk("throughput_ready", 32'(br_ready), 32'd1);
      redirect_ready = 1'b0;
      return;
    end
    if (mode == 2) begin
      flush_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0;
      chk("flush_redir_valid", 32'(redirect_valid), 32'd0);
      chk("flush_redir_ready", 32'(br_ready), 32'd1);
      return;
    end
    if (mode == 3) begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("arst_redirect_pc", redirect_pc, 32'd0);
      chk("arst_br_ready", 32'(br_ready), 32'd1);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_res_taken", 32'(res_taken), 32'd0);
      chk("arst_res_link", res_link, 32'd0);
      chk("arst_res_mispredict", 32'(res_mispredict), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    repeat (dly) @(negedge clk);
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    chk("redirect_done_ready", 32'(br_ready), 32'd1);
    chk("redirect_done_valid", 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, imm, a, b, s;
    int mode;

    repeat (3) @(negedge clk);
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_res_link", res_link, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'd0, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0, 0, 0);
    send(2'd0, 3'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1,
         1'b1, 0, 0);
    send(2'd0, 3'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1,
         1'b0, 0, 0);
    send(2'd2, 3'd0, 32'h200, 32'h0, 32'h1003, 32'h0,
         1'b0, 0, 0);
    send(2'd2, 3'd0, 32'h200, 32'h0, 32'h1001, 32'h0,
         1'b0, 0, 0);
    send(2'd0, 3'd1, 32'h400, 32'h80, 32'h7, 32'h9,
         1'b0, 0, 3);
    send(2'd0, 3'd1, 32'h400, 32'h80, 32'h7, 32'h9,
         1'b0, 1, 0);
    send(2'd0, 3'd1, 32'h400, 32'h80, 32'h7, 32'h9,
         1'b0, 2, 0);
    send(2'd0, 3'd2, 32'h500, 32'h10, 32'h1, 32'h1,
         1'b1, 0, 0);
    send(2'd3, 3'd0, 32'h500, 32'h10, 32'h1, 32'h1,
         1'b0, 0, 0);
    send(2'd1, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0,
         1'b0, 0, 1);
    send(2'd0, 3'd5, 32'h600, 32'h30, 32'h8000_0000, 32'h1,
         1'b1, 3, 0);

    // valid together with flush in IDLE must not be accepted
    br_valid = 1'b1;
    flush_in = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", 32'(br_ready), 32'd1);
    br_valid = 1'b0;
    flush_in = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_res", 32'(res_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 7);
      op = (r < 5) ? 2'd0 : 2'(r - 4);
      f3 = (op == 2'd1 || op == 2'd2)
           ? 3'd0 : 3'($urandom_range(0, 7));
      pc = ($urandom_range(0, 9) == 0)
           ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      s   = $urandom;
      imm = ($urandom_range(0, 3) == 0)
            ? s : {{20{s[11]}}, s[11:1], 1'b0};
      a = $urandom;
      r = $urandom_range(0, 3);
      b = (r == 0) ? a : (r == 1) ? ~a : $urandom;
      r = $urandom_range(0, 15);
      mode = (r < 11) ? 0 : (r < 13) ? 1 : (r < 15) ? 2 : 3;
      send(op, f3, pc, imm, a, b, 1'($urandom_range(0, 1)),
           mode, $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
